node_pkt_arbiter: RTL and testbench
===================================

NODE_PKT_ARBITER -- requirements
Module: node_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of local requesters sharing one router_core node port (2..8).
REQ-002 SHALL have parameter PKT_W, default 29, meaning packet width {dest addr[28:25], flag[24], payload[23:0]}.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning max cycles to wait for Core_Load_Ack (1..255).
REQ-004 SHALL have a single clock and an asynchronous active-low reset, as given by REQ-005 and REQ-006.
REQ-005 SHALL have port Clk_R  input  1  router core clock; all state on rising edge.
REQ-006 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port Req_Valid  input  NUM_REQ  per-requester packet pending; bit i = requester i.
REQ-008 SHALL have port Req_Packet  input  NUM_REQ*PKT_W  flattened packets; requester i at bits [i*PKT_W +: PKT_W].
REQ-009 SHALL have port Req_Ack  output  NUM_REQ  one-cycle pulse: requester's packet accepted by core.
REQ-010 SHALL have port Packet_From_Node  output  PKT_W  packet presented to router_core.
REQ-011 SHALL have port Packet_From_Node_Valid  output  1  packet presented to router_core is valid.
REQ-012 SHALL have port Core_Load_Ack  input  1  router_core has loaded the presented packet.
REQ-013 SHALL have port Grant_Id  output  3  index of the current or last granted requester.
REQ-014 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port Timeout_Err  output  1  one-cycle pulse when a grant is abandoned.

Function
REQ-016 SHALL implement FSM states IDLE, PRESENT, HOLDOFF.
REQ-017 IDLE with any Req_Valid bit set SHALL select a winner round-robin, starting at pointer rr_ptr and ascending with wrap; SHALL latch that winner's packet into Packet_From_Node and its index into Grant_Id; SHALL go to PRESENT.
REQ-018 Packet_From_Node_Valid SHALL be registered and rise on the edge that enters PRESENT, i.e. one cycle after the request is sampled.
REQ-019 In PRESENT, Packet_From_Node and Packet_From_Node_Valid SHALL be held stable; changes to Req_Packet or Req_Valid of the granted requester SHALL be ignored.
REQ-020 In PRESENT, Core_Load_Ack sampled high SHALL:
 - clear Packet_From_Node_Valid next edge;
 - pulse Req_Ack[Grant_Id] for exactly one cycle;
 - set rr_ptr = (Grant_Id+1) mod NUM_REQ;
 - go to HOLDOFF.
REQ-021 PRESENT SHALL count cycles in an 8-bit counter cleared on entry; reaching TIMEOUT without Core_Load_Ack SHALL:
 - clear Packet_From_Node_Valid;
 - pulse Timeout_Err;
 - leave Req_Ack low;
 - set rr_ptr = (Grant_Id+1) mod NUM_REQ;
 - go to HOLDOFF.
REQ-022 Core_Load_Ack and TIMEOUT reached in the same cycle SHALL be treated as an acknowledge; no Timeout_Err.
REQ-023 HOLDOFF SHALL last exactly one cycle with Packet_From_Node_Valid low, then go to IDLE, giving the core a valid-low gap between packets.
REQ-024 Core_Load_Ack in IDLE or HOLDOFF SHALL be ignored.
REQ-025 Minimum period per packet SHALL be 3 cycles (IDLE, PRESENT with immediate ack, HOLDOFF).
REQ-026 rr_ptr SHALL wrap from NUM_REQ-1 to 0; a lone requester SHALL be granted regardless of rr_ptr.
REQ-027 Requesters SHALL hold Req_Valid until Req_Ack or Timeout_Err; requester i may re-assert in the cycle after its Req_Ack.

Reset
REQ-028 Rst_n low SHALL asynchronously set state=IDLE, rr_ptr=0, counter=0.
REQ-029 Rst_n low SHALL asynchronously clear outputs: Packet_From_Node=0, Packet_From_Node_Valid=0, Req_Ack=0, Grant_Id=0, Busy=0, Timeout_Err=0.
REQ-030 Reset mid-PRESENT SHALL drop valid immediately and issue no Req_Ack or Timeout_Err.

Structure
REQ-031 Shared package router_pkg SHALL hold the packet field positions (address 28:25, flag 24, payload 23:0), PKT_W, and the arbiter state encodings.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_priority_picker (inputs: request vector, rr_ptr; outputs: grant index, any_req).

Verification
REQ-033 Req_Valid=0001, Req_Packet0={4'b0001,1'b0,24'd42}, Core_Load_Ack 2 cycles after valid -> Packet_From_Node=0x200002A, Req_Ack[0] single pulse, Busy 4 cycles.
REQ-034 Req_Valid=1111 held, core acks immediately -> grants 0,1,2,3,0 on consecutive packets, 3 cycles apart.
REQ-035 Req_Valid=0100, Core_Load_Ack never, TIMEOUT=255 -> Timeout_Err pulse 255 cycles after valid rise, Req_Ack stays 0, next grant skips requester 2 if others pending.
REQ-036 rr_ptr=3, Req_Valid=1001 -> requester 3 granted first, then 0 (wrap).
REQ-037 Rst_n pulsed low in PRESENT -> valid low within the same cycle, no ack; after release Req_Valid=0010 -> requester 1 granted from rr_ptr=0.
REQ-038 Core_Load_Ack on exactly the TIMEOUT cycle -> Req_Ack pulse, no Timeout_Err.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: packet field layout, default packet width and the
// arbiter state encoding.
package router_pkg;
  localparam int PKT_W    = 29;
  localparam int ADDR_HI  = 28;
  localparam int ADDR_LO  = 25;
  localparam int FLAG_BIT = 24;
  localparam int PAY_HI   = 23;
  localparam int PAY_LO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLDOFF = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_HI-ADDR_LO:0] addr;
    logic                     flag;
    logic [PAY_HI-PAY_LO:0]   payload;
  } pkt_t;

  function automatic logic [PKT_W-1:0] make_pkt(input logic [3:0] addr, input logic flag,
                                                input logic [23:0] payload);
    pkt_t p;
    p.addr    = addr;
    p.flag    = flag;
    p.payload = payload;
    return p;
  endfunction
endpackage

// File: rtl/node_pkt_arbiter_if.sv
// Requester/core side bundle of the node packet arbiter.
interface node_pkt_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int PKT_W   = router_pkg::PKT_W
);
  logic [NUM_REQ-1:0]       Req_Valid;
  logic [NUM_REQ*PKT_W-1:0] Req_Packet;
  logic [NUM_REQ-1:0]       Req_Ack;
  logic [PKT_W-1:0]         Packet_From_Node;
  logic                     Packet_From_Node_Valid;
  logic                     Core_Load_Ack;
  logic [2:0]               Grant_Id;
  logic                     Busy;
  logic                     Timeout_Err;

  // master: requesters plus core (drive requests and load-ack)
  modport master (
    output Req_Valid, Req_Packet, Core_Load_Ack,
    input  Req_Ack, Packet_From_Node, Packet_From_Node_Valid, Grant_Id, Busy, Timeout_Err
  );
  modport slave (
    input  Req_Valid, Req_Packet, Core_Load_Ack,
    output Req_Ack, Packet_From_Node, Packet_From_Node_Valid, Grant_Id, Busy, Timeout_Err
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_priority_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         grant,
  output logic               any_req
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [3:0]           sum;

  // rotate so bit 0 is the pointer position, then take the lowest set bit
  always_comb begin
    dbl     = {req, req};
    rot     = NUM_REQ'(dbl >> ptr);
    any_req = |req;
    sum     = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (rot[k]) sum = {1'b0, ptr} + 4'(k);
    grant = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
  end
endmodule

// File: rtl/node_pkt_arbiter.sv
// Arbitrates NUM_REQ local requesters onto one router_core node port with
// round-robin fairness, load-ack handshake, timeout and a one-cycle holdoff gap.
module node_pkt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PKT_W   = router_pkg::PKT_W,
  parameter int TIMEOUT = 255
) (
  input  logic                     Clk_R,
  input  logic                     Rst_n,
  input  logic [NUM_REQ-1:0]       Req_Valid,
  input  logic [NUM_REQ*PKT_W-1:0] Req_Packet,
  output logic [NUM_REQ-1:0]       Req_Ack,
  output logic [PKT_W-1:0]         Packet_From_Node,
  output logic                     Packet_From_Node_Valid,
  input  logic                     Core_Load_Ack,
  output logic [2:0]               Grant_Id,
  output logic                     Busy,
  output logic                     Timeout_Err
);
  import router_pkg::*;

  arb_state_e       state, nxt;
  logic [2:0]       rr_ptr, win;
  logic [7:0]       cnt;
  logic             any_req, grant_en, ack_hit, to_hit, done;
  logic [PKT_W-1:0] pkt_sel;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (Req_Valid),
    .ptr     (rr_ptr),
    .grant   (win),
    .any_req (any_req)
  );

  always_ff @(posedge Clk_R or negedge Rst_n)
    if (!Rst_n) state <= ST_IDLE;
    else        state <= nxt;

  // ack has priority over timeout on the final PRESENT cycle
  assign ack_hit = (state == ST_PRESENT) && Core_Load_Ack;
  assign to_hit  = (state == ST_PRESENT) && !Core_Load_Ack && (cnt == 8'(TIMEOUT-1));

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (any_req) nxt = ST_PRESENT;
      ST_PRESENT: if (ack_hit || to_hit) nxt = ST_HOLDOFF;
      ST_HOLDOFF: nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy     = (state != ST_IDLE);
    grant_en = (state == ST_IDLE) && any_req;
    done     = ack_hit || to_hit;
  end

  always_comb begin
    pkt_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == 3'(i)) pkt_sel = Req_Packet[i*PKT_W +: PKT_W];
  end

  always_ff @(posedge Clk_R or negedge Rst_n)
    if (!Rst_n) begin
      Packet_From_Node       <= '0;
      Packet_From_Node_Valid <= 1'b0;
      Grant_Id               <= '0;
      Req_Ack                <= '0;
      Timeout_Err            <= 1'b0;
      rr_ptr                 <= '0;
      cnt                    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) Req_Ack[i] <= ack_hit && (Grant_Id == 3'(i));
      Timeout_Err <= to_hit;
      if (grant_en) begin
        Packet_From_Node       <= pkt_sel;
        Grant_Id               <= win;
        Packet_From_Node_Valid <= 1'b1;
        cnt                    <= '0;
      end else if (state == ST_PRESENT) begin
        cnt <= cnt + 8'd1;
      end
      if (done) begin
        Packet_From_Node_Valid <= 1'b0;
        rr_ptr <= (Grant_Id == 3'(NUM_REQ-1)) ? 3'd0 : Grant_Id + 3'd1;
      end
    end
endmodule

// File: tb/tb_node_pkt_arbiter.sv
// Directed bench for node_pkt_arbiter: single packet, round-robin, wrap,
// timeout, ack-on-timeout-cycle and reset during PRESENT.
module tb_node_pkt_arbiter;
  import router_pkg::*;

  logic Clk_R = 1'b0;
  logic Rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  node_pkt_arbiter_if #(.NUM_REQ(4), .PKT_W(29)) bus();

  node_pkt_arbiter #(.NUM_REQ(4), .PKT_W(29), .TIMEOUT(255)) dut (
    .Clk_R                  (Clk_R),
    .Rst_n                  (Rst_n),
    .Req_Valid              (bus.Req_Valid),
    .Req_Packet             (bus.Req_Packet),
    .Req_Ack                (bus.Req_Ack),
    .Packet_From_Node       (bus.Packet_From_Node),
    .Packet_From_Node_Valid (bus.Packet_From_Node_Valid),
    .Core_Load_Ack          (bus.Core_Load_Ack),
    .Grant_Id               (bus.Grant_Id),
    .Busy                   (bus.Busy),
    .Timeout_Err            (bus.Timeout_Err)
  );

  always #5 Clk_R = ~Clk_R;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk_R);
    #1;
  endtask

  function automatic logic [28:0] rp(input int i);
    return make_pkt(4'(i + 8), i[0], 24'(i * 16 + 5));
  endfunction

  initial begin
    bus.Req_Valid     = '0;
    bus.Req_Packet    = '0;
    bus.Core_Load_Ack = 1'b0;
    #12;
    chk("rst_valid", bus.Packet_From_Node_Valid, 0);
    chk("rst_pkt",   bus.Packet_From_Node, 0);
    chk("rst_ack",   bus.Req_Ack, 0);
    chk("rst_gid",   bus.Grant_Id, 0);
    chk("rst_busy",  bus.Busy, 0);
    chk("rst_terr",  bus.Timeout_Err, 0);
    @(negedge Clk_R);
    Rst_n = 1'b1;
    tick();

    // single packet, core acks two cycles after valid
    bus.Req_Packet[0 +: 29] = {4'b0001, 1'b0, 24'd42};
    bus.Req_Valid = 4'b0001;
    tick();
    chk("a_valid", bus.Packet_From_Node_Valid, 1);
    chk("a_pkt",   bus.Packet_From_Node, 32'h200002A);
    chk("a_gid",   bus.Grant_Id, 0);
    chk("a_busy0", bus.Busy, 1);
    bus.Req_Packet[0 +: 29] = 29'h0;
    tick();
    chk("a_hold_pkt", bus.Packet_From_Node, 32'h200002A);
    chk("a_hold_ack", bus.Req_Ack, 0);
    tick();
    bus.Core_Load_Ack = 1'b1;
    tick();
    chk("a_ack",     bus.Req_Ack, 4'b0001);
    chk("a_vld_off", bus.Packet_From_Node_Valid, 0);
    chk("a_busy3",   bus.Busy, 1);
    bus.Core_Load_Ack = 1'b0;
    bus.Req_Valid = '0;
    tick();
    chk("a_ack_pulse", bus.Req_Ack, 0);
    chk("a_idle",      bus.Busy, 0);

    // restart from rr_ptr=0, all requesting, immediate ack
    Rst_n = 1'b0;
    #1;
    Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) bus.Req_Packet[i*29 +: 29] = rp(i);
    bus.Req_Valid = 4'b1111;
    bus.Core_Load_Ack = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("b_gid", bus.Grant_Id, g % 4);
      chk("b_pkt", bus.Packet_From_Node, rp(g % 4));
      tick();
      chk("b_ack", bus.Req_Ack, 4'b0001 << (g % 4));
      tick();
      chk("b_gap", bus.Busy, 0);
    end
    // rr_ptr now 1; grant requester 2 alone to move it to 3
    bus.Req_Valid = 4'b0100;
    tick();
    chk("d_lone", bus.Grant_Id, 2);
    tick();
    bus.Req_Valid = '0;
    tick();
    bus.Req_Valid = 4'b1001;
    tick();
    chk("d_first3", bus.Grant_Id, 3);
    tick();
    chk("d_ack3", bus.Req_Ack, 4'b1000);
    bus.Req_Valid = 4'b0001;
    tick(2);
    chk("d_wrap0", bus.Grant_Id, 0);
    tick();
    chk("d_ack0", bus.Req_Ack, 4'b0001);
    bus.Req_Valid = '0;
    bus.Core_Load_Ack = 1'b0;
    tick();

    // timeout on requester 2 (rr_ptr=1 here)
    bus.Req_Valid = 4'b0100;
    tick();
    chk("c_gid", bus.Grant_Id, 2);
    tick(254);
    chk("c_pre_terr", bus.Timeout_Err, 0);
    chk("c_pre_vld",  bus.Packet_From_Node_Valid, 1);
    tick();
    chk("c_terr",     bus.Timeout_Err, 1);
    chk("c_no_ack",   bus.Req_Ack, 0);
    chk("c_vld_off",  bus.Packet_From_Node_Valid, 0);
    bus.Req_Valid = 4'b0101;
    tick();
    chk("c_terr_pulse", bus.Timeout_Err, 0);
    tick();
    chk("c_skip2", bus.Grant_Id, 0);
    bus.Core_Load_Ack = 1'b1;
    tick();
    chk("c_ack0", bus.Req_Ack, 4'b0001);
    bus.Core_Load_Ack = 1'b0;
    bus.Req_Valid = '0;
    tick();

    // ack on the final PRESENT cycle wins over timeout (rr_ptr=1)
    bus.Req_Valid = 4'b0010;
    tick();
    chk("e_gid", bus.Grant_Id, 1);
    tick(254);
    chk("e_pre_vld", bus.Packet_From_Node_Valid, 1);
    bus.Core_Load_Ack = 1'b1;
    tick();
    chk("e_ack",  bus.Req_Ack, 4'b0010);
    chk("e_terr", bus.Timeout_Err, 0);
    bus.Core_Load_Ack = 1'b0;
    bus.Req_Valid = '0;
    tick();

    // reset while PRESENT (rr_ptr=2)
    bus.Req_Valid = 4'b1000;
    tick();
    chk("f_gid", bus.Grant_Id, 3);
    chk("f_vld", bus.Packet_From_Node_Valid, 1);
    bus.Core_Load_Ack = 1'b1;
    Rst_n = 1'b0;
    #1;
    chk("f_vld_async",  bus.Packet_From_Node_Valid, 0);
    chk("f_busy_async", bus.Busy, 0);
    chk("f_gid_async",  bus.Grant_Id, 0);
    tick();
    chk("f_no_ack",  bus.Req_Ack, 0);
    chk("f_no_terr", bus.Timeout_Err, 0);
    Rst_n = 1'b1;
    bus.Core_Load_Ack = 1'b0;
    bus.Req_Valid = 4'b0010;
    tick();
    chk("f_gid1", bus.Grant_Id, 1);
    chk("f_pkt1", bus.Packet_From_Node, rp(1));
    bus.Core_Load_Ack = 1'b1;
    tick();
    chk("f_ack1", bus.Req_Ack, 4'b0010);
    bus.Core_Load_Ack = 1'b0;
    bus.Req_Valid = '0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
